// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and defaults for the counter family
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/down_count_timer_if.sv
// rtl/down_count_timer_if.sv - control/status bundle of the countdown timer
interface down_count_timer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load_val, start, pause, abort,
    input  count, busy, done
  );

  modport slave (
    input  load_val, start, pause, abort,
    output count, busy, done
  );
endinterface

// File: rtl/down_count_stage.sv
// rtl/down_count_stage.sv - one falling-edge T cell with synchronous load
module down_count_stage (
  input  logic clk,
  input  logic rstn,
  input  logic ld,
  input  logic d,
  input  logic t,
  output logic q
);

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/down_count_timer.sv
// rtl/down_count_timer.sv - loadable countdown timer built from toggle cells
module down_count_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rstn,
  down_count_timer_if.slave tif
);

  timer_state_t     state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] tgl;
  logic             ld;
  logic             en;
  logic             busy_q;
  logic             done_q;

  // Abort clears the count through the same load path a start uses.
  always_comb begin
    ld      = 1'b0;
    ld_data = '0;
    en      = 1'b0;
    case (state)
      IDLE: begin
        ld      = tif.start && (tif.load_val != '0);
        ld_data = tif.load_val;
      end
      RUN: begin
        ld = tif.abort;
        en = !tif.abort && !tif.pause;
      end
      HOLD: begin
        ld = tif.abort;
      end
      default: begin
        ld = 1'b1;
      end
    endcase
  end

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_stage
      if (i == 0) begin : g_lsb
        assign tgl[i] = en;
      end else begin : g_borrow
        assign tgl[i] = en && (cnt[i-1:0] == '0);
      end

      down_count_stage u_stage (
        .clk  (clk),
        .rstn (rstn),
        .ld   (ld),
        .d    (ld_data[i]),
        .t    (tgl[i]),
        .q    (cnt[i])
      );
    end
  endgenerate

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (tif.start) begin
            if (tif.load_val != '0) begin
              state  <= RUN;
              busy_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (tif.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (tif.pause) begin
            state <= HOLD;
          end else if (cnt == WIDTH'(1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        HOLD: begin
          if (tif.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (!tif.pause) begin
            state <= RUN;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign tif.count = cnt;
  assign tif.busy  = busy_q;
  assign tif.done  = done_q;

endmodule
